// File: rtl/note_sequencer.sv
// Note sequencer: classifies PS/2 make codes into length-select, note and flush
// actions, queues notes in a small FIFO and plays them as timed gate pulses.
module note_sequencer #(
    parameter int unsigned TICKS_PER_UNIT = 12500000,
    parameter int unsigned GAP_TICKS      = 1250000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          key_valid,
    input  logic [7:0]                    key_code,
    input  logic [2:0]                    mlength,
    output logic                          note_on,
    output logic [2:0]                    note_idx,
    output logic [2:0]                    note_len,
    output logic [2:0]                    length_sel,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = PTR_W + 1;
    localparam int unsigned DUR_W = $clog2(8 * TICKS_PER_UNIT) + 1;
    localparam int unsigned GAP_W = $clog2(GAP_TICKS + 1);
    localparam int unsigned CNT_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_GAP
    } state_t;

    typedef struct packed {
        logic [2:0] idx;
        logic [2:0] len;
    } note_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   target_q;
    logic               note_on_q;
    logic [2:0]         note_idx_q;
    logic [2:0]         note_len_q;
    logic [2:0]         length_sel_q;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic               busy_q;
    logic               busy_d;
    logic               overflow_q;
    logic               overflow_d;
    note_t              mem [FIFO_DEPTH];

    logic               is_digit;
    logic               is_note;
    logic               is_esc;
    logic [2:0]         key_idx;
    logic               flush;
    logic               push;
    logic               pop;
    logic               play_done;
    logic               gap_done;
    note_t              head;
    logic [31:0]        load_prod;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        is_digit = 1'b0;
        is_note  = 1'b0;
        is_esc   = 1'b0;
        key_idx  = 3'd0;
        case (key_code)
            8'h16, 8'h1E, 8'h26, 8'h25,
            8'h2E, 8'h36, 8'h3D, 8'h3E: is_digit = 1'b1;
            8'h1C: begin is_note = 1'b1; key_idx = 3'd0; end
            8'h1B: begin is_note = 1'b1; key_idx = 3'd1; end
            8'h23: begin is_note = 1'b1; key_idx = 3'd2; end
            8'h2B: begin is_note = 1'b1; key_idx = 3'd3; end
            8'h34: begin is_note = 1'b1; key_idx = 3'd4; end
            8'h33: begin is_note = 1'b1; key_idx = 3'd5; end
            8'h3B: begin is_note = 1'b1; key_idx = 3'd6; end
            8'h42: begin is_note = 1'b1; key_idx = 3'd7; end
            8'h76: is_esc = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        flush      = key_valid && is_esc;
        overflow_d = key_valid && is_note && (count_q == CW'(FIFO_DEPTH));
        push       = key_valid && is_note && (count_q != CW'(FIFO_DEPTH));
        pop        = (state_q == S_IDLE) && (count_q != '0) && !flush;
        play_done  = (state_q == S_PLAY) && (cnt_q == target_q - CNT_W'(1));
        gap_done   = (state_q == S_GAP) && (cnt_q == CNT_W'(GAP_TICKS - 1));
        head       = mem[rd_ptr_q];
        load_prod  = ({29'd0, head.len} + 32'd1) * TICKS_PER_UNIT;
        count_d    = flush ? '0 : count_q + CW'(push) - CW'(pop);
        // Busy is registered from next-state values so it lines up with state and count.
        busy_d     = !flush && ((count_d != '0) || pop || (state_q == S_PLAY)
                                || ((state_q == S_GAP) && !gap_done));
    end

    // NOTE: queue storage has no reset; count and pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= '{idx: key_idx, len: length_sel_q};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            target_q     <= '0;
            note_on_q    <= 1'b0;
            note_idx_q   <= 3'd0;
            note_len_q   <= 3'd0;
            length_sel_q <= 3'd0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            if (key_valid && is_digit) begin
                length_sel_q <= mlength;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (flush) begin
                state_q   <= S_IDLE;
                note_on_q <= 1'b0;
                cnt_q     <= '0;
                rd_ptr_q  <= '0;
                wr_ptr_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (pop) begin
                            note_idx_q <= head.idx;
                            note_len_q <= head.len;
                            target_q   <= load_prod[CNT_W-1:0];
                            cnt_q      <= '0;
                            note_on_q  <= 1'b1;
                            rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                            state_q    <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (play_done) begin
                            note_on_q <= 1'b0;
                            cnt_q     <= '0;
                            state_q   <= S_GAP;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (gap_done) begin
                            cnt_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign note_on    = note_on_q;
    assign note_idx   = note_idx_q;
    assign note_len   = note_len_q;
    assign length_sel = length_sel_q;
    assign fifo_count = count_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios plus random key traffic, all
// checked every cycle against a queue-and-remaining-time reference model.
module tb_note_sequencer;

    localparam int T = 4;
    localparam int G = 2;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic [2:0] mlength = 3'd0;
    logic       note_on;
    logic [2:0] note_idx;
    logic [2:0] note_len;
    logic [2:0] length_sel;
    logic [2:0] fifo_count;
    logic       busy;
    logic       overflow;

    note_sequencer #(.TICKS_PER_UNIT(T), .GAP_TICKS(G), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .mlength(mlength), .note_on(note_on), .note_idx(note_idx),
        .note_len(note_len), .length_sel(length_sel), .fifo_count(fifo_count),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of pending notes and the time left in the current phase.
    typedef enum {M_IDLE, M_PLAY, M_GAP} phase_t;
    typedef struct {int idx; int len;} mnote_t;

    logic [7:0] note_codes [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};
    logic [7:0] digit_codes[8] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};

    mnote_t q[$];
    phase_t m_phase = M_IDLE;
    int m_rem = 0, m_on = 0, m_idx = 0, m_len = 0, m_lsel = 0, m_ovf = 0, m_busy = 0;

    function automatic int note_pos(input logic [7:0] c);
        for (int i = 0; i < 8; i++) if (note_codes[i] == c) return i;
        return -1;
    endfunction

    function automatic int digit_pos(input logic [7:0] c);
        for (int i = 0; i < 8; i++) if (digit_codes[i] == c) return i;
        return -1;
    endfunction

    task automatic model_update();
        int ni, di;
        bit do_pop, accept;
        mnote_t e;
        ni = note_pos(key_code);
        di = digit_pos(key_code);
        if (reset) begin
            q.delete();
            m_phase = M_IDLE; m_rem = 0; m_on = 0; m_idx = 0; m_len = 0;
            m_lsel = 0; m_ovf = 0; m_busy = 0;
            return;
        end
        m_ovf = 0;
        if (key_valid && key_code == 8'h76) begin
            q.delete();
            m_phase = M_IDLE;
            m_on = 0;
        end else begin
            do_pop = (m_phase == M_IDLE) && (q.size() != 0);
            accept = 0;
            if (key_valid && ni >= 0) begin
                if (q.size() == D) m_ovf = 1;
                else accept = 1;
            end
            if (m_phase == M_PLAY) begin
                m_rem--;
                if (m_rem == 0) begin m_on = 0; m_phase = M_GAP; m_rem = G; end
            end else if (m_phase == M_GAP) begin
                m_rem--;
                if (m_rem == 0) m_phase = M_IDLE;
            end
            if (do_pop) begin
                e = q.pop_front();
                m_idx = e.idx; m_len = e.len; m_on = 1;
                m_phase = M_PLAY; m_rem = (e.len + 1) * T;
            end
            if (accept) begin
                e.idx = ni; e.len = m_lsel;
                q.push_back(e);
            end
            if (key_valid && di >= 0) m_lsel = int'(mlength);
        end
        m_busy = (m_phase != M_IDLE || q.size() != 0) ? 1 : 0;
    endtask

    task automatic compare_all();
        check("note_on",    note_on,    m_on);
        check("note_idx",   note_idx,   m_idx);
        check("note_len",   note_len,   m_len);
        check("length_sel", length_sel, m_lsel);
        check("fifo_count", fifo_count, q.size());
        check("busy",       busy,       m_busy);
        check("overflow",   overflow,   m_ovf);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
        key_valid = 1'b0;
        key_code  = 8'($urandom);
        mlength   = 3'($urandom);
    endtask

    task automatic press(input logic [7:0] code, input logic [2:0] ml);
        key_valid = 1'b1;
        key_code  = code;
        mlength   = ml;
        step();
    endtask

    task automatic wait_on(input int limit);
        int k = 0;
        while (note_on !== 1'b1 && k < limit) begin step(); k++; end
        check("wait_note_on", note_on, 1);
    endtask

    task automatic measure(input logic level, output int w);
        w = 0;
        while (note_on === level && w < 200) begin step(); w++; end
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (busy !== 1'b0 && k < limit) begin step(); k++; end
        check("wait_idle", busy, 0);
    endtask

    int w, k, peak;

    initial begin
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        check("rst_note_on", note_on, 0);
        check("rst_fifo", fifo_count, 0);
        check("rst_busy", busy, 0);

        // Single note: latency, width and busy tail.
        press(8'h1C, 3'd5);
        check("lat_fifo_n1", fifo_count, 1);
        step();
        check("lat_on_n2", note_on, 1);
        check("lat_fifo_n2", fifo_count, 0);
        measure(1'b1, w);
        check("width_len0", w, 4);
        k = 0;
        while (busy === 1'b1 && k < 20) begin step(); k++; end
        check("busy_tail", k, 2);

        // Length select then note K.
        press(8'h26, 3'd2);
        check("lsel_2", length_sel, 2);
        press(8'h42, 3'd0);
        wait_on(10);
        check("idx_7", note_idx, 7);
        check("len_2", note_len, 2);
        measure(1'b1, w);
        check("width_len2", w, 12);
        wait_idle(20);

        // Back-to-back notes.
        press(8'h1E, 3'd0);
        press(8'h1B, 3'd0);
        peak = fifo_count;
        press(8'h23, 3'd0);
        if (fifo_count > peak) peak = fifo_count;
        wait_on(10);
        measure(1'b1, w);
        check("b2b_w1", w, 4);
        measure(1'b0, w);
        check("b2b_gap", w, 3);
        check("b2b_idx2", note_idx, 2);
        measure(1'b1, w);
        check("b2b_w2", w, 4);
        check("b2b_peak", peak, 1);
        wait_idle(20);

        // Overflow during a long note.
        press(8'h3E, 3'd7);
        press(8'h1C, 3'd0);
        wait_on(10);
        for (int i = 1; i <= 4; i++) press(note_codes[i], 3'd0);
        check("ovf_full", fifo_count, 4);
        press(note_codes[5], 3'd0);
        check("ovf_pulse", overflow, 1);
        step();
        check("ovf_clear", overflow, 0);
        measure(1'b1, w);
        for (int i = 1; i <= 4; i++) begin
            wait_on(20);
            check("ovf_order", note_idx, i);
            measure(1'b1, w);
            check("ovf_width", w, 32);
        end
        wait_idle(20);

        // Flush mid-note with three queued.
        press(8'h1C, 3'd0);
        wait_on(10);
        for (int i = 0; i < 3; i++) press(note_codes[i + 2], 3'd0);
        repeat (2) step();
        press(8'h76, 3'd0);
        check("esc_on", note_on, 0);
        check("esc_fifo", fifo_count, 0);
        check("esc_busy", busy, 0);
        press(8'h16, 3'd0);
        press(8'h3B, 3'd0);
        wait_on(10);
        check("post_esc_idx", note_idx, 6);
        measure(1'b1, w);
        check("post_esc_w", w, 4);
        wait_idle(20);

        // Ignored key, then reset mid-note.
        press(8'h29, 3'd5);
        check("ign_lsel", length_sel, 0);
        check("ign_fifo", fifo_count, 0);
        press(8'h25, 3'd3);
        press(8'h34, 3'd0);
        press(8'h33, 3'd0);
        wait_on(10);
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_on", note_on, 0);
        check("rst_mid_idx", note_idx, 0);
        check("rst_mid_lsel", length_sel, 0);
        check("rst_mid_fifo", fifo_count, 0);
        check("rst_mid_busy", busy, 0);

        // Random key traffic.
        for (int n = 0; n < 3000; n++) begin
            int r;
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 4) == 0) begin
                r = $urandom_range(0, 19);
                key_valid = 1'b1;
                if (r < 10)       key_code = note_codes[$urandom_range(0, 7)];
                else if (r < 15)  key_code = digit_codes[$urandom_range(0, 7)];
                else if (r == 15) key_code = 8'h76;
                else              key_code = 8'($urandom);
            end
            step();
            reset = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
